watch_display: RTL

- Drives a 4-digit multiplexed 7-segment display from a 12-hour time count.
- Inputs: hour (0..11, where 0 is shown as 12) and minute (0..59), both supplied by the team's hour/minute counter.
- Converts binary to decimal digits, scans one digit at a time and blinks the colon.
- Sits between the timekeeping counter and the board pins.

---
 rtl/watch_pkg.sv | 27 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/watch_display.sv | 112 +++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared constants for the watch display: digit codes and active-low {g,f,e,d,c,b,a} segment patterns.
package watch_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned DIGITS = 4;

  // Digit code: 0..9 are decimal digits, 10 is a dash, 11 is a blank digit.
  typedef logic [CODE_W-1:0] digit_t;

  localparam digit_t DIG_DASH  = 4'd10;
  localparam digit_t DIG_BLANK = 4'd11;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low 7-segment pattern decoder.
module seg7_decode
  import watch_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (code)
      4'd0:     seg_c = SEG_0;
      4'd1:     seg_c = SEG_1;
      4'd2:     seg_c = SEG_2;
      4'd3:     seg_c = SEG_3;
      4'd4:     seg_c = SEG_4;
      4'd5:     seg_c = SEG_5;
      4'd6:     seg_c = SEG_6;
      4'd7:     seg_c = SEG_7;
      4'd8:     seg_c = SEG_8;
      4'd9:     seg_c = SEG_9;
      DIG_DASH: seg_c = SEG_DASH;
      default:  seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/watch_display.sv
// 4-digit multiplexed 7-segment driver for a 12-hour hh:mm time with a blinking colon.
module watch_display
  import watch_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 250,
  parameter int unsigned LZ_BLANK     = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        hour,
  input  logic [5:0]        minute,
  output logic [SEG_W-1:0]  seg,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [3:0]    snap_h;
  logic [5:0]    snap_m;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          colon;

  logic          tick;
  logic          frame_start;
  logic [1:0]    dig_next;
  logic [3:0]    src_h;
  logic [5:0]    src_m;
  logic [3:0]    disp_h;
  digit_t        h_tens, h_ones, m_tens, m_ones, sel_code;
  logic [SEG_W-1:0] seg_c;

  assign tick        = (cnt == CW'(SCAN_DIV - 1));
  assign dig_next    = dig + 2'd1;
  assign frame_start = tick && (dig == 2'd3);

  // Digit 0 of a frame comes straight from the live inputs; the rest from the frame snapshot.
  always_comb begin
    src_h  = frame_start ? hour   : snap_h;
    src_m  = frame_start ? minute : snap_m;
    disp_h = (src_h == 4'd0) ? 4'd12 : src_h;
    h_tens = DIG_DASH;
    h_ones = DIG_DASH;
    m_tens = DIG_DASH;
    m_ones = DIG_DASH;
    if (src_h < 4'd12) begin
      if (disp_h >= 4'd10) begin
        h_tens = 4'd1;
        h_ones = disp_h - 4'd10;
      end else begin
        h_tens = (LZ_BLANK != 0) ? DIG_BLANK : 4'd0;
        h_ones = disp_h;
      end
    end
    if (src_m < 6'd60) begin
      m_tens = 4'(src_m / 6'd10);
      m_ones = 4'(src_m % 6'd10);
    end
    case (dig_next)
      2'd0:    sel_code = m_ones;
      2'd1:    sel_code = m_tens;
      2'd2:    sel_code = h_ones;
      default: sel_code = h_tens;
    endcase
  end

  seg7_decode u_dec (
    .code  (sel_code),
    .seg_c (seg_c)
  );

  // Scan/blink state; the colon state is latched per frame alongside the time snapshot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      dig       <= 2'd3;
      snap_h    <= '0;
      snap_m    <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      colon     <= 1'b1;
      seg       <= SEG_BLANK;
      an        <= 4'hF;
      dp        <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        dig <= dig_next;
        an  <= ~(4'b0001 << dig_next);
        seg <= seg_c;
        dp  <= ~(colon && (dig_next == 2'd2));
        if (frame_start) begin
          snap_h <= hour;
          snap_m <= minute;
          colon  <= phase;
          if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
      end
    end
  end

endmodule
